// File: rtl/bus_burst_responder_pkg.sv
// Shared definitions for the burst-bus responder.
//  - state_t   : responder FSM states
//  - BUS_W     : bus data width (address/data phases share one 32-bit lane)
//  - BE_W      : number of byte lanes
//  - CNT_W     : remaining-word counter width (burst_size is words-1, so up to 256 words)
//  - lane_mask : expands byte enables into a 32-bit data mask
package bus_burst_responder_pkg;

  localparam int BUS_W = 32;
  localparam int BE_W  = 4;
  localparam int CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FETCH,
    ST_RD_DATA,
    ST_RD_END,
    ST_WR_DATA,
    ST_ERROR,
    ST_ERR_WAIT
  } state_t;

  function automatic logic [BUS_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bus_burst_responder.sv
// Responder end of the shared burst bus, backed by an external synchronous RAM.
// A transaction is selected when begin_transactionIN carries an address inside
// the window at Base. Reads stream RAM words (lane-masked) with busyIN
// back-pressure; writes go straight to the RAM in the cycle data_validIN is seen.
// Bursts that would run past the end of the window are rejected with errorOUT.
//
// Ports
//  clock, n_reset          : clock, asynchronous active-low reset
//  begin_transactionIN     : start of transaction, address/control valid
//  address_dataIN          : byte address on begin, write data afterwards
//  read_n_writeIN          : 1 = read, 0 = write
//  byte_enableIN           : byte lanes for the whole transaction
//  burst_sizeIN            : words-1
//  data_validIN            : write data word valid
//  end_transactionIN       : initiator ends / aborts
//  busyIN                  : initiator stalls read data
//  address_dataOUT         : read data
//  data_validOUT           : read data valid
//  end_transactionOUT      : pulse after last read word or read error
//  errorOUT                : pulse on window overrun
//  busyOUT                 : always 0
//  mem_*                   : RAM port (read data has one cycle latency)
module bus_burst_responder
  import bus_burst_responder_pkg::*;
#(
  parameter logic [31:0] Base      = 32'h4000_0000,
  parameter int          AddrWidth = 9
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 begin_transactionIN,
  input  logic [BUS_W-1:0]     address_dataIN,
  input  logic                 read_n_writeIN,
  input  logic [BE_W-1:0]      byte_enableIN,
  input  logic [7:0]           burst_sizeIN,
  input  logic                 data_validIN,
  input  logic                 end_transactionIN,
  input  logic                 busyIN,
  output logic [BUS_W-1:0]     address_dataOUT,
  output logic                 data_validOUT,
  output logic                 end_transactionOUT,
  output logic                 errorOUT,
  output logic                 busyOUT,
  output logic [AddrWidth-1:0] mem_address,
  output logic [BUS_W-1:0]     mem_dataIn,
  output logic [BE_W-1:0]      mem_byteEnable,
  output logic                 mem_writeEnable,
  input  logic [BUS_W-1:0]     mem_dataOut
);

  localparam int SUM_W = AddrWidth + 2;
  localparam logic [SUM_W-1:0] WINDOW = SUM_W'(1) << AddrWidth;

  state_t               state_q, state_d;
  logic                 rnw_q, rnw_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 select;
  logic [AddrWidth-1:0] req_addr;
  logic [CNT_W-1:0]     req_cnt;

  // Sum is kept wide enough that start+length can never wrap before the compare.
  function automatic logic burst_overruns(input logic [AddrWidth-1:0] a,
                                          input logic [CNT_W-1:0]     r);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(r);
    return sum > WINDOW;
  endfunction

  assign select   = begin_transactionIN &&
                    (address_dataIN[31:AddrWidth+2] == Base[31:AddrWidth+2]);
  assign req_addr = address_dataIN[AddrWidth+1:2];
  assign req_cnt  = {1'b0, burst_sizeIN} + CNT_W'(1);
  assign busyOUT  = 1'b0;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // All bus outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    state_d            = state_q;
    rnw_d              = rnw_q;
    be_d               = be_q;
    addr_d             = addr_q;
    cnt_d              = cnt_q;
    address_dataOUT    = '0;
    data_validOUT      = 1'b0;
    end_transactionOUT = 1'b0;
    errorOUT           = 1'b0;
    mem_address        = addr_q;
    mem_dataIn         = address_dataIN;
    mem_byteEnable     = be_q;
    mem_writeEnable    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (select) begin
          rnw_d  = read_n_writeIN;
          be_d   = byte_enableIN;
          addr_d = req_addr;
          cnt_d  = req_cnt;
          if (burst_overruns(req_addr, req_cnt)) state_d = ST_ERROR;
          else if (read_n_writeIN)               state_d = ST_RD_FETCH;
          else                                   state_d = ST_WR_DATA;
        end
      end

      ST_RD_FETCH: begin
        state_d = end_transactionIN ? ST_IDLE : ST_RD_DATA;
      end

      ST_RD_DATA: begin
        data_validOUT   = 1'b1;
        address_dataOUT = mem_dataOut & lane_mask(be_q);
        if (end_transactionIN) begin
          state_d = ST_IDLE;
        end else if (!busyIN) begin
          // Present the next address now so its data arrives next cycle;
          // while stalled the RAM keeps re-reading the same word.
          addr_d      = addr_q + AddrWidth'(1);
          cnt_d       = cnt_q - CNT_W'(1);
          mem_address = addr_q + AddrWidth'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_RD_END;
        end
      end

      ST_RD_END: begin
        end_transactionOUT = 1'b1;
        state_d            = ST_IDLE;
      end

      ST_WR_DATA: begin
        if (data_validIN && (cnt_q != '0)) begin
          mem_writeEnable = 1'b1;
          addr_d          = addr_q + AddrWidth'(1);
          cnt_d           = cnt_q - CNT_W'(1);
        end
        if (end_transactionIN) state_d = ST_IDLE;
      end

      ST_ERROR: begin
        errorOUT = 1'b1;
        if (rnw_q)                  state_d = ST_RD_END;
        else if (end_transactionIN) state_d = ST_IDLE;
        else                        state_d = ST_ERR_WAIT;
      end

      ST_ERR_WAIT: begin
        if (end_transactionIN) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_burst_responder.sv
module tb_bus_burst_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int WORDS = 512;
  localparam int K_WORD = 0, K_END = 1, K_ERR = 2;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        begin_transactionIN;
  logic [31:0] address_dataIN;
  logic        read_n_writeIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        data_validIN;
  logic        end_transactionIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        errorOUT;
  logic        busyOUT;
  logic [8:0]  mem_address;
  logic [31:0] mem_dataIn;
  logic [3:0]  mem_byteEnable;
  logic        mem_writeEnable;
  logic [31:0] mem_dataOut;

  bus_burst_responder #(.Base(BASE), .AddrWidth(9)) dut (
    .clock              (clock),
    .n_reset            (n_reset),
    .begin_transactionIN(begin_transactionIN),
    .address_dataIN     (address_dataIN),
    .read_n_writeIN     (read_n_writeIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .data_validIN       (data_validIN),
    .end_transactionIN  (end_transactionIN),
    .busyIN             (busyIN),
    .address_dataOUT    (address_dataOUT),
    .data_validOUT      (data_validOUT),
    .end_transactionOUT (end_transactionOUT),
    .errorOUT           (errorOUT),
    .busyOUT            (busyOUT),
    .mem_address        (mem_address),
    .mem_dataIn         (mem_dataIn),
    .mem_byteEnable     (mem_byteEnable),
    .mem_writeEnable    (mem_writeEnable),
    .mem_dataOut        (mem_dataOut)
  );

  always #5 clock = ~clock;

  // Scratch RAM seen by the DUT, plus an independent reference image.
  logic [31:0] tb_ram [WORDS];
  logic [31:0] ref_mem[WORDS];

  always @(posedge clock) begin
    if (mem_writeEnable)
      for (int l = 0; l < 4; l++)
        if (mem_byteEnable[l]) tb_ram[mem_address][8*l +: 8] <= mem_dataIn[8*l +: 8];
    mem_dataOut <= tb_ram[mem_address];
  end

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int cyc_cnt = 0;
  int acc_cnt = 0;
  int first_vld_cyc = -1;
  int end_cyc = -1;
  bit end_seen = 0;
  bit wr_phase = 0;
  int bad_writes = 0;
  logic        prev_vld = 0;
  logic        prev_busy = 0;
  logic [31:0] prev_data = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 0;
    for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic pop_cmp(input int kind, input logic [31:0] data, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check(0, {"unexpected_", name}, data, 32'(kind));
    end else begin
      e = exp_q.pop_front();
      check(e.kind == kind && (kind != K_WORD || e.data == data), name, data,
            (e.kind == kind) ? e.data : 32'hBAD0_0000 | 32'(e.kind));
    end
  endtask

  // Monitor: every accepted word / pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (n_reset) begin
      if (data_validOUT && prev_vld && prev_busy)
        check(address_dataOUT == prev_data, "held_word", address_dataOUT, prev_data);
      if (data_validOUT && first_vld_cyc < 0) first_vld_cyc = cyc_cnt;
      if (data_validOUT && !busyIN) begin
        pop_cmp(K_WORD, address_dataOUT, "read_word");
        acc_cnt++;
      end
      if (end_transactionOUT) begin
        pop_cmp(K_END, 32'h0, "end_pulse");
        end_seen = 1;
        end_cyc  = cyc_cnt;
      end
      if (errorOUT) pop_cmp(K_ERR, 32'h0, "error_pulse");
      if (mem_writeEnable && !wr_phase) bad_writes++;
      prev_vld  = data_validOUT;
      prev_busy = busyIN;
      prev_data = address_dataOUT;
    end else begin
      prev_vld = 0;
    end
  end

  task automatic idle_inputs();
    begin_transactionIN = 0;
    address_dataIN      = 0;
    read_n_writeIN      = 0;
    byte_enableIN       = 0;
    burst_sizeIN        = 0;
    data_validIN        = 0;
    end_transactionIN   = 0;
    busyIN              = 0;
  endtask

  task automatic issue_begin(input logic [31:0] addr, input bit rnw,
                             input logic [3:0] be, input int burst);
    @(posedge clock); #1;
    begin_transactionIN = 1;
    address_dataIN      = addr;
    read_n_writeIN      = rnw;
    byte_enableIN       = be;
    burst_sizeIN        = 8'(burst);
  endtask

  // busy_mode: 0 random stalls, 1 stall 3 cycles on the second word, 2 never stall.
  task automatic run_read(input logic [31:0] addr, input int burst, input logic [3:0] be,
                          input int busy_mode, input int abort_after);
    bit sel;
    int a, n, cyc, busy_cnt, begin_cyc, words;
    bit aborted;
    exp_t e;
    sel   = (addr[31:11] == BASE[31:11]);
    a     = int'(addr[10:2]);
    n     = burst + 1;
    words = 0;
    if (sel) begin
      if (a + n > WORDS) begin
        e.kind = K_ERR; e.data = 0; exp_q.push_back(e);
      end else begin
        for (int i = 0; i < n; i++) begin
          e.kind = K_WORD; e.data = ref_mem[a + i] & be_mask(be); exp_q.push_back(e);
        end
        words = n;
      end
      e.kind = K_END; e.data = 0; exp_q.push_back(e);
    end
    acc_cnt = 0; end_seen = 0; first_vld_cyc = -1; end_cyc = -1;
    issue_begin(addr, 1'b1, be, burst);
    begin_cyc = cyc_cnt;
    @(posedge clock); #1;
    begin_transactionIN = 0;
    address_dataIN      = $urandom;
    if (!sel) begin
      repeat (6) @(posedge clock);
      #1;
      return;
    end
    cyc = 0; busy_cnt = 0; aborted = 0;
    while (cyc < 400) begin
      if (end_seen) break;
      if (abort_after >= 0 && acc_cnt >= abort_after) begin
        end_transactionIN = 1;
        busyIN            = 0;
        @(posedge clock); #1;
        end_transactionIN = 0;
        exp_q.delete();
        @(negedge clock);
        check(!data_validOUT && !end_transactionOUT && !errorOUT, "abort_idle",
              {29'b0, data_validOUT, end_transactionOUT, errorOUT}, 32'h0);
        @(posedge clock); #1;
        aborted = 1;
        break;
      end
      case (busy_mode)
        0: busyIN = ($urandom_range(0, 2) == 0);
        1: begin
          busyIN = (acc_cnt == 1 && busy_cnt < 3);
          if (busyIN) busy_cnt++;
        end
        default: busyIN = 0;
      endcase
      @(posedge clock); #1;
      cyc++;
    end
    busyIN = 0;
    if (!end_seen && !aborted) begin
      check(0, "read_timeout", 32'(cyc), 32'h0);
      exp_q.delete();
    end
    if (end_seen) begin
      check(acc_cnt == words, "accepted_count", 32'(acc_cnt), 32'(words));
      if (words > 0)
        check(first_vld_cyc - begin_cyc == 2, "first_latency",
              32'(first_vld_cyc - begin_cyc), 32'd2);
      if (busy_mode == 2)
        check(end_cyc - begin_cyc == 2 + words, "end_latency",
              32'(end_cyc - begin_cyc), 32'(2 + words));
      check(exp_q.size() == 0, "read_drained", 32'(exp_q.size()), 32'h0);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input int burst, input logic [3:0] be,
                           input int ndata, input bit end_with_last);
    bit sel, ovr;
    int a, n, hi;
    logic [31:0] d;
    exp_t e;
    sel = (addr[31:11] == BASE[31:11]);
    a   = int'(addr[10:2]);
    n   = burst + 1;
    ovr = (a + n > WORDS);
    if (sel && ovr) begin
      e.kind = K_ERR; e.data = 0; exp_q.push_back(e);
    end
    wr_phase = 1;
    issue_begin(addr, 1'b0, be, burst);
    @(posedge clock); #1;
    begin_transactionIN = 0;
    for (int i = 0; i < ndata; i++) begin
      data_validIN = 0;
      address_dataIN = $urandom;
      for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
        @(posedge clock); #1;
      end
      d                 = $urandom;
      address_dataIN    = d;
      data_validIN      = 1;
      end_transactionIN = end_with_last && (i == ndata - 1);
      if (sel && !ovr && i < n)
        ref_mem[a + i] = (ref_mem[a + i] & ~be_mask(be)) | (d & be_mask(be));
      @(posedge clock); #1;
    end
    data_validIN = 0;
    if (!end_transactionIN) begin
      end_transactionIN = 1;
      @(posedge clock); #1;
    end
    end_transactionIN = 0;
    @(posedge clock); #1;
    wr_phase = 0;
    hi = a + ndata;
    if (hi > WORDS - 1) hi = WORDS - 1;
    for (int w = a; w <= hi; w++)
      check(tb_ram[w] == ref_mem[w], "ram_word", tb_ram[w], ref_mem[w]);
    check(exp_q.size() == 0, "write_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic reset_mid_burst();
    exp_t e;
    int cyc;
    for (int i = 0; i < 8; i++) begin
      e.kind = K_WORD; e.data = ref_mem[16 + i]; exp_q.push_back(e);
    end
    e.kind = K_END; e.data = 0; exp_q.push_back(e);
    acc_cnt = 0;
    issue_begin(BASE + 32'h40, 1'b1, 4'hF, 7);
    @(posedge clock); #1;
    begin_transactionIN = 0;
    cyc = 0;
    while (acc_cnt < 2 && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check(acc_cnt >= 2, "reset_setup", 32'(acc_cnt), 32'd2);
    #2 n_reset = 0;
    #1;
    check(address_dataOUT == 0 && !data_validOUT && !end_transactionOUT && !errorOUT &&
          !mem_writeEnable && !busyOUT, "reset_async_outputs", address_dataOUT,
          32'h0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 n_reset = 1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) tb_ram[i] <= $urandom;
    tb_ram[4] <= 32'hDEAD_BEEF;
    idle_inputs();
    n_reset = 0;
    #1;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = tb_ram[i];
    repeat (3) @(posedge clock);
    #1;
    check(address_dataOUT == 0 && !data_validOUT && !end_transactionOUT && !errorOUT &&
          !busyOUT && !mem_writeEnable, "reset_state", address_dataOUT, 32'h0);
    n_reset = 1;

    run_read(BASE + 32'h10, 0, 4'hF, 2, -1);
    run_read(BASE, 3, 4'hF, 1, -1);
    run_write(BASE + 32'h20, 1, 4'h3, 3, 1'b1);
    run_read(BASE + 32'h20, 1, 4'hF, 2, -1);
    run_read(BASE + 32'h7FC, 1, 4'hF, 0, -1);
    run_write(BASE + 32'h7F8, 4, 4'hF, 3, 1'b0);
    run_read(32'h5000_0000, 2, 4'hF, 2, -1);
    run_write(32'h5000_0040, 1, 4'hF, 2, 1'b0);
    run_read(BASE + 32'h100, 9, 4'hA, 0, 3);
    run_read(BASE + 32'h7F8, 1, 4'h5, 2, -1);
    reset_mid_burst();
    run_read(BASE + 32'h10, 0, 4'hF, 2, -1);

    for (int t = 0; t < 30; t++) begin
      logic [31:0] addr;
      int burst;
      logic [3:0] be;
      addr  = BASE + {21'b0, 9'($urandom_range(0, WORDS - 1)), 2'b00};
      if ($urandom_range(0, 3) == 0) addr = BASE + {21'b0, 9'($urandom_range(480, 511)), 2'b00};
      if ($urandom_range(0, 9) == 0) addr = addr ^ 32'h0100_0000;
      burst = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      be    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        run_read(addr, burst, be, $urandom_range(0, 2),
                 ($urandom_range(0, 4) == 0 && addr[10:2] + burst < 511) ?
                   $urandom_range(0, burst) : -1);
      else
        run_write(addr, burst, be, $urandom_range(0, burst + 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clock);
    #1;
    check(bad_writes == 0, "no_stray_write", 32'(bad_writes), 32'h0);
    check(exp_q.size() == 0, "queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule
